// File: rtl/axis_header_tx.sv
// AXI-Stream framer: prefixes each payload frame with the "HFTCHILE" header beat.
// Define AXIS_TX_SEQ_EN to insert a 64-bit sequence-number beat after the header.
module axis_header_tx (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [63:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [31:0] frame_count,
   output logic        busy
);

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 32;
   localparam logic [DATA_W-1:0] HEADER = 64'h4846544348494C45;

   // HDR_SENT is never entered; it decodes back to IDLE if ever reached.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HDR_SENT = 2'd1,
      SEQ      = 2'd2,
      BODY     = 2'd3
   } state_t;

`ifdef AXIS_TX_SEQ_EN
   localparam state_t AFTER_HDR = SEQ;
`else
   localparam state_t AFTER_HDR = BODY;
`endif

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   tdata_q, tdata_d;
   logic                tvalid_q, tvalid_d;
   logic                tlast_q, tlast_d;
   logic [CNT_W-1:0]    frame_count_q, frame_count_d;
   logic                adv;
   logic                s_ready;
`ifdef AXIS_TX_SEQ_EN
   logic [DATA_W-1:0]   seq_q, seq_d;
`endif

   // Output register may load when empty or being drained this cycle.
   assign adv = !tvalid_q || m_axis_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         tdata_q       <= '0;
         tvalid_q      <= 1'b0;
         tlast_q       <= 1'b0;
         frame_count_q <= '0;
`ifdef AXIS_TX_SEQ_EN
         seq_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         tdata_q       <= tdata_d;
         tvalid_q      <= tvalid_d;
         tlast_q       <= tlast_d;
         frame_count_q <= frame_count_d;
`ifdef AXIS_TX_SEQ_EN
         seq_q         <= seq_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      tdata_d       = tdata_q;
      tlast_d       = tlast_q;
      tvalid_d      = adv ? 1'b0 : tvalid_q;
      s_ready       = 1'b0;
      frame_count_d = frame_count_q;
`ifdef AXIS_TX_SEQ_EN
      seq_d         = seq_q;
`endif
      if (tvalid_q && m_axis_tready && tlast_q) begin
         frame_count_d = frame_count_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            // Header is emitted without consuming the waiting payload beat.
            if (s_axis_tvalid && adv) begin
               tdata_d  = HEADER;
               tlast_d  = 1'b0;
               tvalid_d = 1'b1;
               state_d  = AFTER_HDR;
            end
         end
`ifdef AXIS_TX_SEQ_EN
         SEQ: begin
            if (adv) begin
               tdata_d  = seq_q;
               tlast_d  = 1'b0;
               tvalid_d = 1'b1;
               seq_d    = seq_q + DATA_W'(1);
               state_d  = BODY;
            end
         end
`endif
         BODY: begin
            s_ready = adv;
            if (s_axis_tvalid && adv) begin
               tdata_d  = s_axis_tdata;
               tlast_d  = s_axis_tlast;
               tvalid_d = 1'b1;
               if (s_axis_tlast) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign frame_count   = frame_count_q;
   assign busy          = (state_q != IDLE) || tvalid_q;

endmodule

// File: tb/tb_axis_header_tx.sv
// Self-checking bench for axis_header_tx: queue-based frame model plus directed timing checks.
module tb_axis_header_tx;

   localparam logic [63:0] HEADER = 64'h4846544348494C45;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [31:0] frame_count;
   logic        busy;

   axis_header_tx dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .frame_count   (frame_count),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   beat_t       src_q[$];
   beat_t       exp_q[$];
   int          out_cyc[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          ready_pct   = 100;
   int          stall_cnt   = 0;
   int          frames_done = 0;
   logic        prev_stall  = 1'b0;
   logic [63:0] prev_data   = '0;
   logic        prev_last   = 1'b0;
   logic [63:0] seq_model   = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: a frame becomes header, optional sequence beat, then payload unchanged.
   task automatic add_frame(input int n, input logic [63:0] d0, input logic [63:0] d1, input bit rnd);
      beat_t b;
      exp_q.push_back({HEADER, 1'b0});
`ifdef AXIS_TX_SEQ_EN
      exp_q.push_back({seq_model, 1'b0});
      seq_model = seq_model + 64'd1;
`endif
      for (int i = 0; i < n; i++) begin
         b.data = rnd ? {$urandom, $urandom} : ((i == 0) ? d0 : d1);
         b.last = (i == n - 1);
         src_q.push_back(b);
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      beat_t e;
      @(negedge aclk);
      if (stall_cnt > 0) begin
         m_axis_tready = 1'b0;
         stall_cnt--;
      end else begin
         m_axis_tready = (int'($urandom_range(99)) < ready_pct);
      end
      if (src_q.size() > 0) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = src_q[0].data;
         s_axis_tlast  = src_q[0].last;
      end else begin
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = '0;
         s_axis_tlast  = 1'b0;
      end
      #1;
      if (prev_stall) begin
         chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
         chk("stall_data", m_axis_tdata, prev_data);
         chk("stall_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_axis_tdata, e.data);
            chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
            if (e.last) frames_done++;
            out_cyc.push_back(cyc);
         end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (s_axis_tvalid && s_axis_tready) void'(src_q.pop_front());
      cyc++;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      tick();
      chk("idle_valid", 64'(m_axis_tvalid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("frame_count", 64'(frame_count), 64'(frames_done));
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      src_q.delete();
      exp_q.delete();
      out_cyc.delete();
      seq_model   = '0;
      frames_done = 0;
      prev_stall  = 1'b0;
      stall_cnt   = 0;
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   int c0;
   int nb;

   initial begin
      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_data", m_axis_tdata, 64'd0);
      chk("rst_last", 64'(m_axis_tlast), 64'd0);
      chk("rst_count", 64'(frame_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sready", 64'(s_axis_tready), 64'd0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;

      // Basic two-beat frame at full rate: beats on consecutive cycles right after presentation.
      ready_pct = 100;
      add_frame(2, 64'h1111111111111111, 64'h2222222222222222, 1'b0);
      c0 = cyc;
      nb = exp_q.size();
      drain(50);
      chk("basic_nbeats", 64'(out_cyc.size()), 64'(nb));
      for (int i = 0; i < out_cyc.size(); i++) chk("basic_timing", 64'(out_cyc[i]), 64'(c0 + 1 + i));

      // Backpressure: header held for 3 stalled cycles, nothing consumed.
      do_reset();
      add_frame(2, 64'h3333333333333333, 64'h4444444444444444, 1'b0);
      stall_cnt = 4;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hdr", m_axis_tdata, HEADER);
         chk("bp_sready", 64'(s_axis_tready), 64'd0);
         chk("bp_busy", 64'(busy), 64'd1);
         chk("bp_src_kept", 64'(src_q.size()), 64'd2);
      end
      drain(50);

      // Back-to-back single-beat frames with no gap between them.
      do_reset();
      out_cyc.delete();
      add_frame(1, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b0);
      add_frame(1, 64'hBBBBBBBBBBBBBBBB, 64'h0, 1'b0);
      c0 = cyc;
      nb = exp_q.size();
      drain(50);
      chk("b2b_nbeats", 64'(out_cyc.size()), 64'(nb));
      for (int i = 0; i < out_cyc.size(); i++) chk("b2b_timing", 64'(out_cyc[i]), 64'(c0 + 1 + i));
      chk("b2b_count", 64'(frame_count), 64'd2);

      // Asynchronous reset mid-frame, away from any clock edge.
      add_frame(3, 64'h0, 64'h0, 1'b1);
      tick();
      tick();
      chk("mid_busy", 64'(busy), 64'd1);
      #2;
      aresetn = 1'b0;
      #1;
      chk("arst_valid", 64'(m_axis_tvalid), 64'd0);
      chk("arst_count", 64'(frame_count), 64'd0);
      chk("arst_data", m_axis_tdata, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      src_q.delete();
      exp_q.delete();
      seq_model   = '0;
      frames_done = 0;
      prev_stall  = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      add_frame(2, 64'h0, 64'h0, 1'b1);
      drain(50);

      // Random downstream stalls over 100 frames of 1-16 beats.
      do_reset();
      ready_pct = 50;
      for (int f = 0; f < 100; f++) add_frame(int'($urandom_range(16, 1)), 64'h0, 64'h0, 1'b1);
      drain(20000);
      chk("rand_count", 64'(frame_count), 64'd100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axis_header_tx.md
# axis_header_tx

AXI-Stream framer/transmitter: accepts raw 64-bit payload frames on a slave AXI-Stream port and emits them on a master AXI-Stream port, prefixed with the 8-byte "HFTCHILE" header beat. It is the transmit-side counterpart of the header-matching parser and produces streams that parser detects. It sits between the strategy/order-generation logic and the network MAC. The master output is fully registered.

## Interface
- HEADER, 64'h4846544348494C45, header beat value ("HFTCHILE", big-endian byte order, byte 0 in [63:56])
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset; asynchronous, active-low (single clock domain)
- s_axis_tdata  in  64  payload beat
- s_axis_tvalid  in  1  upstream payload beat valid
- s_axis_tready  out  1  framer accepts payload beat
- s_axis_tlast  in  1  last payload beat of frame
- m_axis_tdata  out  64  output beat
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream accepts output beat
- m_axis_tlast  out  1  last beat of output frame
- frame_count  out  32  frames fully delivered downstream; wraps modulo 2^32
- busy  out  1  state != IDLE or m_axis_tvalid = 1

## Operation
- Single output register (tdata/tvalid/tlast). Define adv = !m_axis_tvalid || m_axis_tready; the register loads only when adv = 1. If adv = 1 and nothing loads, m_axis_tvalid clears to 0.
- States: IDLE, HDR_SENT, SEQ (only with AXIS_TX_SEQ_EN), BODY.
- IDLE: s_axis_tready = 0. If s_axis_tvalid && adv: load HEADER, tlast = 0, go to SEQ (if enabled) else BODY. The payload beat is not consumed.
- SEQ: s_axis_tready = 0. If adv: load seq_num, tlast = 0, increment seq_num, go to BODY.
- BODY: s_axis_tready = adv (combinational from m_axis_tready and m_axis_tvalid). On s handshake: load s_axis_tdata, tlast = s_axis_tlast; if s_axis_tlast, go to IDLE.
- frame_count increments on m_axis_tvalid && m_axis_tready && m_axis_tlast.
- A single-beat frame (tlast on first beat) emits header, [seq], payload with tlast = 1.
- Payload data is passed unmodified; there is no length limit.
- While m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata and m_axis_tlast hold stable (AXI-Stream rule).
- Once asserted, m_axis_tvalid stays high until the handshake completes.

## Timing
- Reset values: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, frame_count = 0, seq_num = 0, state IDLE, busy = 0, s_axis_tready = 0.
- Latency with m_axis_tready = 1:
  - Header is visible on m_axis one cycle after the first s_axis_tvalid in IDLE.
  - The first payload beat is visible one cycle after the header (two cycles with SEQ).
- Throughput in BODY: one beat per cycle, no bubbles.
- Per-frame overhead: 1 cycle (2 with SEQ). Back-to-back frames: the header of frame N+1 loads the cycle after frame N's tlast beat loads.
- Reset mid-frame (asynchronous): outputs clear immediately and any pending beat is dropped. The partial frame is abandoned and never completed; the next frame starts with a header. Upstream must also restart its frame.
- Upstream asserting s_axis_tvalid while the output is stalled in IDLE: the header waits for adv; nothing is consumed.

## Configuration
- AXIS_TX_SEQ_EN defined:
  - A SEQ beat follows the header carrying 64-bit seq_num (0 after reset, +1 per frame, wraps after 2^64-1).
  - Frame = header, seq, payload.
- AXIS_TX_SEQ_EN undefined: no SEQ state and no seq_num register; frame = header, payload.

## Test plan
- Basic frame, m_axis_tready = 1, payload 64'h1111111111111111 then 64'h2222222222222222 (tlast) -> output beats 64'h4846544348494C45/last0, 64'h1111111111111111/last0, 64'h2222222222222222/last1 on consecutive cycles; frame_count = 1.
- Backpressure: hold m_axis_tready = 0 for 3 cycles with header valid -> m_axis_tdata stays 64'h4846544348494C45, s_axis_tready = 0, no payload lost; the frame completes after release.
- Back-to-back single-beat frames A (64'hAAAA...) and B (64'hBBBB...) -> output header, A/last1, header, B/last1 in 4 consecutive cycles; frame_count = 2.
- Async reset after header accepted, mid-frame -> m_axis_tvalid = 0 and frame_count = 0 without a clock edge; the next frame emits a header first.
- AXIS_TX_SEQ_EN: two 1-beat frames -> beats header, 64'h0, P0, header, 64'h1, P1.
- Random m_axis_tready (50%) over 100 frames of 1-16 beats -> scoreboard matches the inserted headers exactly; no tdata change while stalled; frame_count = 100.
